period_readout_scheduler: RTL and testbench

- Sequences readout of the per-pixel PERIOD measurements produced by the eight frequency_counter instances.
- Each counter's PULSE strobe captures its PERIOD into a one-deep per-pixel holding buffer.
- A round-robin arbiter grants buffered pixels one at a time. The granted pixel is emitted as a framed byte stream (header byte, then data bytes) over a valid/ready handshake.
- The block sits between the counter array and the chip output pins. It replaces the per-pixel parallel-to-serial outputs with one shared 8-bit channel.

---
 rtl/period_readout_scheduler_pkg.sv | 18 +
 rtl/period_readout_scheduler_if.sv | 20 ++
 rtl/period_readout_scheduler_rr_arbiter.sv | 43 ++++
 rtl/period_readout_scheduler.sv | 150 +++++++++++++++
 tb/tb_period_readout_scheduler.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/period_readout_scheduler_pkg.sv
// Shared types and constants for the period readout scheduler.
// Frame header layout: {HDR_MARK, overrun, 3'b000, pixel[2:0]}.
package fastreadout_pkg;

    localparam int   PIXELS_MAX = 8;
    localparam logic HDR_MARK   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } rdout_state_t;

    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/period_readout_scheduler_if.sv
// Byte-stream valid/ready channel carrying the framed pixel readout.
interface period_readout_scheduler_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/period_readout_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by the pointer,
// pick the lowest set bit, then rotate the offset back to a pixel index.
module rr_arbiter #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_gnt_valid,
    output logic [W-1:0] o_gnt_idx
);

    logic [N-1:0] w_rot;

    always_comb begin
        int s;
        int off;
        w_rot       = '0;
        off         = 0;
        s           = 0;
        o_gnt_valid = 1'b0;
        o_gnt_idx   = '0;

        for (int k = 0; k < N; k++) begin
            s = int'(i_ptr) + k;
            if (s >= N) s = s - N;
            w_rot[k] = i_req[W'(s)];
        end

        // Descending scan so the smallest offset from the pointer wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_gnt_valid = 1'b1;
                off         = k;
            end
        end

        s = int'(i_ptr) + off;
        if (s >= N) s = s - N;
        o_gnt_idx = W'(s);
    end

endmodule

// File: rtl/period_readout_scheduler.sv
// Buffers per-pixel PERIOD captures and serialises them, one pixel at a time,
// as {header, MSB data byte .. LSB data byte} frames over a valid/ready channel.
module period_readout_scheduler
    import fastreadout_pkg::*;
#(
    parameter int PIXELS       = 8,
    parameter int COUNTER_BITS = 12
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           enable,
    input  logic [PIXELS-1:0]              pulse,
    input  logic [PIXELS*COUNTER_BITS-1:0] period_bus,
    output logic                           busy,
    output logic [PIXELS-1:0]              pending,
    period_readout_scheduler_if.master     stream
);

    localparam int DATA_BYTES = bytes_for(COUNTER_BITS);
    localparam int IDX_W      = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int BIDX_W     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int HDR_IDX_W  = $clog2(PIXELS_MAX);

    rdout_state_t            r_state;
    logic [COUNTER_BITS-1:0] r_buf [PIXELS];
    logic [PIXELS-1:0]       r_pending;
    logic [PIXELS-1:0]       r_ovr;
    logic [IDX_W-1:0]        r_ptr;
    logic [COUNTER_BITS-1:0] r_snap;
    logic [BIDX_W-1:0]       r_bidx;
    logic [7:0]              r_out_data;
    logic                    r_out_valid;
    logic                    r_busy;

    logic                    w_gnt_valid;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic                    w_grant;
    logic [PIXELS-1:0]       w_hit;
    logic [IDX_W-1:0]        w_ptr_next;
    logic [7:0]              w_header;

    function automatic logic [7:0] byte_of(input logic [COUNTER_BITS-1:0] v,
                                           input logic [BIDX_W-1:0]       k);
        logic [8*DATA_BYTES-1:0] ext;
        ext = (8*DATA_BYTES)'(v);
        return ext[8*k +: 8];
    endfunction

    rr_arbiter #(
        .N (PIXELS),
        .W (IDX_W)
    ) u_arb (
        .i_req       (r_pending),
        .i_ptr       (r_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    assign w_grant    = (r_state == IDLE) && enable && w_gnt_valid;
    assign w_ptr_next = (w_gnt_idx == IDX_W'(PIXELS - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_header   = {HDR_MARK, r_ovr[w_gnt_idx], 3'b000, HDR_IDX_W'(w_gnt_idx)};

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < PIXELS; i++) begin
            w_hit[i] = w_grant && (w_gnt_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_ovr       <= '0;
            r_ptr       <= '0;
            r_snap      <= '0;
            r_bidx      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < PIXELS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            // Capture side: a grant and a pulse on the same pixel is a clean
            // hand-off (snapshot takes the old value), never an overrun.
            for (int i = 0; i < PIXELS; i++) begin
                if (w_hit[i]) begin
                    r_pending[i] <= 1'b0;
                    r_ovr[i]     <= 1'b0;
                end
                if (pulse[i]) begin
                    r_buf[i]     <= period_bus[i*COUNTER_BITS +: COUNTER_BITS];
                    r_pending[i] <= 1'b1;
                    if (r_pending[i] && !w_hit[i]) begin
                        r_ovr[i] <= 1'b1;
                    end
                end
            end

            // Stream side: out_valid is 1 throughout HEADER and DATA.
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_snap      <= r_buf[w_gnt_idx];
                        r_ptr       <= w_ptr_next;
                        r_out_data  <= w_header;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= HEADER;
                    end
                end
                HEADER: begin
                    if (stream.out_ready) begin
                        r_out_data <= byte_of(r_snap, BIDX_W'(DATA_BYTES - 1));
                        r_bidx     <= BIDX_W'(DATA_BYTES - 1);
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    if (stream.out_ready) begin
                        if (r_bidx == '0) begin
                            r_out_data  <= '0;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_out_data <= byte_of(r_snap, r_bidx - 1'b1);
                            r_bidx     <= r_bidx - 1'b1;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign stream.out_data  = r_out_data;
    assign stream.out_valid = r_out_valid;
    assign busy             = r_busy;
    assign pending          = r_pending;

    a_stall_stable : assert property (@(posedge CLK) disable iff (!RST_N)
        (r_out_valid && !stream.out_ready) |=> (r_out_valid && $stable(r_out_data)));

endmodule

// File: tb/tb_period_readout_scheduler.sv
// Table-driven and scoreboard bench for the period readout scheduler.
module tb_period_readout_scheduler;

    localparam int PIXELS = 8;
    localparam int CB     = 12;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   enable = 1'b0;
    logic [PIXELS-1:0]      pulse = '0;
    logic [PIXELS*CB-1:0]   period_bus = '0;
    logic                   busy;
    logic [PIXELS-1:0]      pending;

    period_readout_scheduler_if sif();

    period_readout_scheduler #(
        .PIXELS       (PIXELS),
        .COUNTER_BITS (CB)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .enable     (enable),
        .pulse      (pulse),
        .period_bus (period_bus),
        .busy       (busy),
        .pending    (pending),
        .stream     (sif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         pix;
        logic [11:0] period;
        logic [7:0] hdr;
        logic [7:0] b1;
        logic [7:0] b0;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         t_first = -1;
    int         t_last = -1;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    bit         bp_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        if (bp_mode) sif.out_ready = ($urandom_range(0, 9) < 3);
        if (prev_stall) begin
            chk("stall_valid", {31'd0, sif.out_valid}, 32'd1);
            chk("stall_data", {24'd0, sif.out_data}, {24'd0, prev_data});
        end
        if (sif.out_valid && sif.out_ready) begin
            if (t_first < 0) t_first = cyc;
            t_last = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_byte: got %02h, required none (cycle %0d)", sif.out_data, cyc);
            end else begin
                chk("stream_byte", {24'd0, sif.out_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_stall = sif.out_valid && !sif.out_ready;
        prev_data  = sif.out_data;
    endtask

    task automatic cycle();
        check_outputs();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_pix(input int p, input logic [11:0] v);
        period_bus[p*CB +: CB] = v;
        pulse[p] = 1'b1;
    endtask

    task automatic push_frame(input logic [7:0] hdr, input logic [11:0] v);
        exp_q.push_back(hdr);
        exp_q.push_back({4'h0, v[11:8]});
        exp_q.push_back(v[7:0]);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (k < budget && (exp_q.size() != 0 || busy || sif.out_valid)) begin
            cycle();
            k++;
        end
        chk({name, "_left"}, exp_q.size(), 32'd0);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [11:0] v;

        vecs[0] = '{pix: 3, period: 12'hABC, hdr: 8'h83, b1: 8'h0A, b0: 8'hBC};
        vecs[1] = '{pix: 0, period: 12'hFFF, hdr: 8'h80, b1: 8'h0F, b0: 8'hFF};
        vecs[2] = '{pix: 7, period: 12'h001, hdr: 8'h87, b1: 8'h00, b0: 8'h01};
        vecs[3] = '{pix: 5, period: 12'h800, hdr: 8'h85, b1: 8'h08, b0: 8'h00};

        sif.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, sif.out_valid}, 32'd0);
        chk("rst_data", {24'd0, sif.out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pending", {24'd0, pending}, 32'd0);
        rst_n = 1'b1;
        cycle();
        enable = 1'b1;

        // Single-pixel frames with exact header latency.
        for (int i = 0; i < 4; i++) begin
            set_pix(vecs[i].pix, vecs[i].period);
            exp_q.push_back(vecs[i].hdr);
            exp_q.push_back(vecs[i].b1);
            exp_q.push_back(vecs[i].b0);
            cycle();
            pulse = '0;
            chk("single_pending_set", {24'd0, pending}, 32'd1 << vecs[i].pix);
            chk("single_early_valid", {31'd0, sif.out_valid}, 32'd0);
            cycle();
            chk("single_hdr_valid", {31'd0, sif.out_valid}, 32'd1);
            chk("single_hdr_data", {24'd0, sif.out_data}, {24'd0, vecs[i].hdr});
            wait_drain("single", 50);
            chk("single_pending_clr", {24'd0, pending}, 32'd0);
        end

        // All pixels at once, full-rate sink.
        do_reset();
        for (int i = 0; i < PIXELS; i++) begin
            v = 12'(100 + i);
            set_pix(i, v);
            push_frame(8'h80 + 8'(i), v);
        end
        t_first = -1;
        cycle();
        pulse = '0;
        wait_drain("all", 200);
        chk("all_span", t_last - t_first + 1, 32'd31);

        // Overrun while disabled, then a clean frame.
        enable = 1'b0;
        set_pix(5, 12'h111);
        cycle();
        pulse = '0;
        cycle();
        set_pix(5, 12'h222);
        cycle();
        pulse = '0;
        cycle();
        chk("ovr_no_grant", {31'd0, sif.out_valid}, 32'd0);
        chk("ovr_pending", {24'd0, pending}, 32'h20);
        push_frame(8'hC5, 12'h222);
        enable = 1'b1;
        wait_drain("ovr", 50);
        set_pix(5, 12'h333);
        push_frame(8'h85, 12'h333);
        cycle();
        pulse = '0;
        wait_drain("ovr_clean", 50);

        // Same burst as the all-pixel case under random backpressure.
        do_reset();
        for (int i = 0; i < PIXELS; i++) begin
            v = 12'(100 + i);
            set_pix(i, v);
            push_frame(8'h80 + 8'(i), v);
        end
        bp_mode = 1'b1;
        cycle();
        pulse = '0;
        wait_drain("bp", 3000);
        bp_mode = 1'b0;
        sif.out_ready = 1'b1;

        // Pulse lands in the exact grant cycle.
        set_pix(2, 12'h123);
        push_frame(8'h82, 12'h123);
        push_frame(8'h82, 12'h456);
        cycle();
        set_pix(2, 12'h456);
        cycle();
        pulse = '0;
        chk("coll_pending", {31'd0, pending[2]}, 32'd1);
        chk("coll_hdr_valid", {31'd0, sif.out_valid}, 32'd1);
        wait_drain("coll", 50);

        // Reset in the middle of a DATA byte.
        do_reset();
        set_pix(1, 12'h5A5);
        set_pix(6, 12'h3C3);
        exp_q.push_back(8'h81);
        cycle();
        pulse = '0;
        cycle();
        cycle();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", {31'd0, sif.out_valid}, 32'd0);
        chk("mid_pending", {24'd0, pending}, 32'd0);
        chk("mid_busy_clr", {31'd0, busy}, 32'd0);
        chk("mid_left", exp_q.size(), 32'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_pix(6, 12'h3C3);
        set_pix(1, 12'h5A5);
        push_frame(8'h81, 12'h5A5);
        push_frame(8'h86, 12'h3C3);
        cycle();
        pulse = '0;
        wait_drain("post_rst", 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
